// File: rtl/keyexp_ctrl.sv
// keyexp_ctrl: control sequencer for the AES-128 round-key expansion datapath (strobes only, no key data).
// Optional sticky error flag output "err" is enabled by defining KEYEXP_CTRL_ERRCHK_EN.
module keyexp_ctrl #(
  parameter int NR        = 10,
  parameter int KEY_BYTES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ld_start,
  input  logic       key_in_valid,
  input  logic       start,
  input  logic       mode,
  input  logic       rk_next,
  output logic       loadkey,
  output logic [1:0] keysel,
  output logic       rndkren,
  output logic [3:0] rconsel,
  output logic       sboxinsel,
  output logic       deckeywen,
  output logic       key_ok,
  output logic       busy,
  output logic       rk_valid,
  output logic [3:0] rk_round,
  output logic       rk_done
`ifdef KEYEXP_CTRL_ERRCHK_EN
  ,
  output logic       err
`endif
);

  localparam int              BW        = $clog2(KEY_BYTES);
  localparam logic [BW-1:0]   LAST_BYTE = BW'(KEY_BYTES - 1);
  localparam logic [3:0]      LAST_RND  = 4'(NR);
  localparam logic [3:0]      LAST_EXP  = 4'(NR - 1);
  localparam logic [1:0]      KS_LOADED = 2'd0;
  localparam logic [1:0]      KS_DECREG = 2'd1;
  localparam logic [1:0]      KS_NEXT   = 2'd2;
  localparam logic [1:0]      KS_PREV   = 2'd3;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PRE, S_EXP, S_SESS} state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   byte_q, byte_d;
  logic [3:0]      exp_q, exp_d;
  logic [3:0]      rk_round_q, rk_round_d;
  logic            mode_q, mode_d;
  logic            key_ok_q, key_ok_d;
  logic            rk_valid_q, rk_valid_d;
  logic            rk_done_q, rk_done_d;
  logic            busy_s;
  logic            exhausted_s;
`ifdef KEYEXP_CTRL_ERRCHK_EN
  logic            err_q, err_d;
`endif

  assign busy_s      = (state_q == S_LOAD) || (state_q == S_PRE) || (state_q == S_EXP);
  // A session is exhausted once the register holds round NR (encrypt) or round 0 (decrypt).
  assign exhausted_s = (state_q == S_SESS) && (mode_q ? (rk_round_q == 4'd0) : (rk_round_q == LAST_RND));

  assign busy     = busy_s;
  assign key_ok   = key_ok_q;
  assign rk_valid = rk_valid_q;
  assign rk_round = rk_round_q;
  assign rk_done  = rk_done_q;
`ifdef KEYEXP_CTRL_ERRCHK_EN
  assign err      = err_q;
`endif

  // Next-state and Mealy strobe decode; ld_start overrides every other input.
  always_comb begin
    state_d    = state_q;
    byte_d     = byte_q;
    exp_d      = exp_q;
    rk_round_d = rk_round_q;
    mode_d     = mode_q;
    key_ok_d   = key_ok_q;
    rk_valid_d = rk_valid_q;
    rk_done_d  = 1'b0;
    loadkey    = 1'b0;
    keysel     = KS_LOADED;
    rndkren    = 1'b0;
    rconsel    = 4'd0;
    sboxinsel  = 1'b0;
    deckeywen  = 1'b0;
`ifdef KEYEXP_CTRL_ERRCHK_EN
    err_d      = err_q | (start && (busy_s || !key_ok_q))
                       | (key_in_valid && (state_q != S_LOAD))
                       | (rk_next && exhausted_s);
`endif
    if (ld_start) begin
      state_d    = S_LOAD;
      byte_d     = '0;
      key_ok_d   = 1'b0;
      rk_valid_d = 1'b0;
`ifdef KEYEXP_CTRL_ERRCHK_EN
      err_d      = 1'b0;
`endif
    end else begin
      case (state_q)
        S_LOAD: begin
          loadkey = key_in_valid;
          if (key_in_valid && (byte_q == LAST_BYTE)) begin
            state_d = S_PRE;
            byte_d  = '0;
          end else if (key_in_valid) begin
            byte_d = byte_q + 1'b1;
          end else begin
            byte_d = byte_q;
          end
        end
        S_PRE: begin
          keysel  = KS_LOADED;
          rndkren = 1'b1;
          exp_d   = 4'd0;
          state_d = S_EXP;
        end
        S_EXP: begin
          keysel  = KS_NEXT;
          rconsel = exp_q;
          rndkren = 1'b1;
          if (exp_q == LAST_EXP) begin
            deckeywen = 1'b1;
            key_ok_d  = 1'b1;
            state_d   = S_IDLE;
          end else begin
            exp_d = exp_q + 4'd1;
          end
        end
        S_IDLE, S_SESS: begin
          if (start && key_ok_q) begin
            rndkren    = 1'b1;
            keysel     = mode ? KS_DECREG : KS_LOADED;
            mode_d     = mode;
            rk_round_d = mode ? LAST_RND : 4'd0;
            rk_valid_d = 1'b1;
            state_d    = S_SESS;
          end else if ((state_q == S_SESS) && rk_next && !exhausted_s && !mode_q) begin
            rndkren    = 1'b1;
            keysel     = KS_NEXT;
            rconsel    = rk_round_q;
            rk_round_d = rk_round_q + 4'd1;
            rk_done_d  = (rk_round_q == (LAST_RND - 4'd1));
          end else if ((state_q == S_SESS) && rk_next && !exhausted_s) begin
            rndkren    = 1'b1;
            keysel     = KS_PREV;
            sboxinsel  = 1'b1;
            rconsel    = rk_round_q - 4'd1;
            rk_round_d = rk_round_q - 4'd1;
            rk_done_d  = (rk_round_q == 4'd1);
          end else begin
            state_d = state_q;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      byte_q     <= '0;
      exp_q      <= 4'd0;
      rk_round_q <= 4'd0;
      mode_q     <= 1'b0;
      key_ok_q   <= 1'b0;
      rk_valid_q <= 1'b0;
      rk_done_q  <= 1'b0;
`ifdef KEYEXP_CTRL_ERRCHK_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      byte_q     <= byte_d;
      exp_q      <= exp_d;
      rk_round_q <= rk_round_d;
      mode_q     <= mode_d;
      key_ok_q   <= key_ok_d;
      rk_valid_q <= rk_valid_d;
      rk_done_q  <= rk_done_d;
`ifdef KEYEXP_CTRL_ERRCHK_EN
      err_q      <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_keyexp_ctrl.sv
// tb_keyexp_ctrl: self-checking bench for keyexp_ctrl with a behavioural control model,
// a key-register datapath model driven by the strobes, and an independent AES-128 key schedule.
module tb_keyexp_ctrl;

  localparam logic [127:0] KEY1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K1_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K1_R9  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] K1_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KEY2   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K2_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ld_start = 1'b0, key_in_valid = 1'b0, start = 1'b0, mode = 1'b0, rk_next = 1'b0;
  logic [7:0] key_byte = 8'h00;
  logic       loadkey, rndkren, sboxinsel, deckeywen, key_ok, busy, rk_valid, rk_done;
  logic [1:0] keysel;
  logic [3:0] rconsel, rk_round;
`ifdef KEYEXP_CTRL_ERRCHK_EN
  logic       err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  keyexp_ctrl dut (
    .clk(clk), .rst(rst), .ld_start(ld_start), .key_in_valid(key_in_valid), .start(start),
    .mode(mode), .rk_next(rk_next), .loadkey(loadkey), .keysel(keysel), .rndkren(rndkren),
    .rconsel(rconsel), .sboxinsel(sboxinsel), .deckeywen(deckeywen), .key_ok(key_ok),
    .busy(busy), .rk_valid(rk_valid), .rk_round(rk_round), .rk_done(rk_done)
`ifdef KEYEXP_CTRL_ERRCHK_EN
    , .err(err)
`endif
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- AES arithmetic (GF(2^8)) ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] t, r, s;
    t = x; r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      t = gmul(t, t);
      r = gmul(r, t);
    end
    if (x == 8'h00) r = 8'h00;
    s = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    return s;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < 10; i++) if (i < int'(idx)) r = gmul(r, 8'h02);
    return r;
  endfunction

  // Datapath step as the top level would wire it: forward (next) or backward (previous) key.
  function automatic logic [127:0] dp_step(input logic [127:0] k, input logic [1:0] ks,
                                           input logic [3:0] rc, input logic sbs);
    logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3, src;
    {w0, w1, w2, w3} = k;
    src = sbs ? (w3 ^ w2) : w3;
    t   = subword({src[23:0], src[31:24]}) ^ {rcon(rc), 24'h000000};
    if (ks == 2'd2) begin
      n0 = w0 ^ t; n1 = n0 ^ w1; n2 = n1 ^ w2; n3 = n2 ^ w3;
    end else begin
      n3 = w3 ^ w2; n2 = w2 ^ w1; n1 = w1 ^ w0; n0 = w0 ^ t;
    end
    return {n0, n1, n2, n3};
  endfunction

  // Reference schedule in the textbook word-array form.
  logic [127:0] sched [11];
  task automatic build_sched(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) sched[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // ---------------- behavioural model state ----------------
  bit  m_loading = 0, m_key_ok = 0, m_rk_valid = 0, m_sess = 0, m_dir = 0, m_done = 0, m_err = 0;
  int  m_bytes = 0, m_exp_left = 0, m_round = 0;
  logic [127:0] dp_rk = '0, dp_dec = '0, dp_sr = '0;
  logic [127:0] seen [11];
  int  cnt_loadkey = 0, cnt_dkw = 0, cnt_done = 0, cnt_rndkren = 0, cnt_decstep = 0;
  logic [3:0] last_dkw_rcon = 4'd0;

  // Per-cycle compare: model predicts every output, then model and datapath advance.
  always @(negedge clk) begin
    logic e_loadkey, e_rndkren, e_sbs, e_dkw, e_busy, e_keyok, e_rkv, e_done, e_err, exhausted, err_set;
    logic [1:0] e_keysel;
    logic [3:0] e_rcon;
    int e_round, step;
    logic [127:0] dp_nx;
    e_loadkey = 0; e_rndkren = 0; e_sbs = 0; e_dkw = 0; e_keysel = 2'd0; e_rcon = 4'd0;
    e_busy = m_loading || (m_exp_left != 0);
    e_keyok = m_key_ok; e_rkv = m_rk_valid; e_round = m_round; e_done = m_done; e_err = m_err;
    if (rst) begin
      e_busy = 0; e_keyok = 0; e_rkv = 0; e_round = 0; e_done = 0; e_err = 0;
      m_loading = 0; m_key_ok = 0; m_rk_valid = 0; m_sess = 0; m_dir = 0; m_done = 0; m_err = 0;
      m_bytes = 0; m_exp_left = 0; m_round = 0;
    end else begin
      m_done = 0;
      exhausted = m_sess && (m_dir ? (m_round == 0) : (m_round == 10));
      err_set = (start && (e_busy || !m_key_ok)) || (key_in_valid && !m_loading) || (rk_next && exhausted);
      if (ld_start) begin
        m_loading = 1; m_bytes = 0; m_exp_left = 0; m_key_ok = 0; m_rk_valid = 0; m_sess = 0; m_err = 0;
      end else begin
        m_err = m_err | err_set;
        if (m_loading) begin
          e_loadkey = key_in_valid;
          if (key_in_valid) m_bytes++;
          if (m_bytes == 16) begin m_loading = 0; m_exp_left = 11; end
        end else if (m_exp_left != 0) begin
          step = 11 - m_exp_left;
          e_rndkren = 1;
          if (step != 0) begin e_keysel = 2'd2; e_rcon = 4'(step - 1); e_dkw = (step == 10); end
          m_exp_left--;
          if (m_exp_left == 0) m_key_ok = 1;
        end else if (start && m_key_ok) begin
          e_rndkren = 1; e_keysel = mode ? 2'd1 : 2'd0;
          m_sess = 1; m_dir = mode; m_round = mode ? 10 : 0; m_rk_valid = 1;
        end else if (m_sess && rk_next && !exhausted) begin
          e_rndkren = 1;
          if (!m_dir) begin e_keysel = 2'd2; e_rcon = 4'(m_round); m_round++; end
          else begin e_keysel = 2'd3; e_sbs = 1; e_rcon = 4'(m_round - 1); m_round--; end
          m_done = m_dir ? (m_round == 0) : (m_round == 10);
        end
      end
    end
    check("loadkey", 128'(loadkey), 128'(e_loadkey));
    check("rndkren", 128'(rndkren), 128'(e_rndkren));
    check("keysel", 128'(keysel), 128'(e_keysel));
    check("rconsel", 128'(rconsel), 128'(e_rcon));
    check("sboxinsel", 128'(sboxinsel), 128'(e_sbs));
    check("deckeywen", 128'(deckeywen), 128'(e_dkw));
    check("busy", 128'(busy), 128'(e_busy));
    check("key_ok", 128'(key_ok), 128'(e_keyok));
    check("rk_valid", 128'(rk_valid), 128'(e_rkv));
    check("rk_round", 128'(rk_round), 128'(e_round));
    check("rk_done", 128'(rk_done), 128'(e_done));
`ifdef KEYEXP_CTRL_ERRCHK_EN
    check("err", 128'(err), 128'(e_err));
`endif
    if (e_rkv) begin
      check("round_key", dp_rk, sched[e_round]);
      seen[e_round] = dp_rk;
    end
    if (!rst) begin
      case (keysel)
        2'd0:    dp_nx = dp_sr;
        2'd1:    dp_nx = dp_dec;
        default: dp_nx = dp_step(dp_rk, keysel, rconsel, sboxinsel);
      endcase
      if (deckeywen) begin dp_dec = dp_nx; cnt_dkw++; last_dkw_rcon = rconsel; end
      if (rndkren) begin dp_rk = dp_nx; cnt_rndkren++; end
      if (rndkren && keysel == 2'd3 && sboxinsel) cnt_decstep++;
      if (loadkey) begin dp_sr = {dp_sr[119:0], key_byte}; cnt_loadkey++; end
      if (rk_done) cnt_done++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [127:0] k, input int gap_at, input bit wait_ok);
    int n;
    build_sched(k);
    ld_start = 1'b1; tick(); ld_start = 1'b0;
    for (int b = 0; b < 16; b++) begin
      if (b == gap_at) begin key_in_valid = 1'b0; tick(); end
      key_in_valid = 1'b1; key_byte = k[127-8*b -: 8]; tick();
    end
    key_in_valid = 1'b0;
    if (wait_ok) begin
      n = 0;
      while (!key_ok && n < 50) begin tick(); n++; end
      check("key_ok_latency", 128'(n), 128'(11));
    end
  endtask

  task automatic run_session(input logic m, input string tag);
    int n;
    start = 1'b1; mode = m; tick(); start = 1'b0; rk_next = 1'b1;
    n = 0;
    while (!rk_done && n < 30) begin tick(); n++; end
    check({tag, "_cycles_to_done"}, 128'(n), 128'(10));
  endtask

  initial begin
    int c_lk, c_dk, c_done, c_ds, c_rk;
    #2 rst = 1'b1;
    tick(); tick();
    check("reset_outputs", 128'({loadkey, keysel, rndkren, rconsel, sboxinsel, deckeywen,
                                 key_ok, busy, rk_valid, rk_round, rk_done}), 128'(0));
    rst = 1'b0; tick();

    // 1: load with one gap
    c_lk = cnt_loadkey; c_dk = cnt_dkw;
    load_key(KEY1, int'($urandom_range(1, 14)), 1'b1);
    check("loadkey_count", 128'(cnt_loadkey - c_lk), 128'(16));
    check("deckeywen_count", 128'(cnt_dkw - c_dk), 128'(1));
    check("deckeywen_rconsel", 128'(last_dkw_rcon), 128'(9));
    check("deckey_round10", dp_dec, K1_R10);

    // 2: encrypt session
    c_done = cnt_done;
    run_session(1'b0, "enc");
    rk_next = 1'b0; tick(); tick();
    check("enc_done_pulses", 128'(cnt_done - c_done), 128'(1));
    check("enc_round1", seen[1], K1_R1);
    check("enc_round10", seen[10], K1_R10);

    // 3: decrypt session, rk_next kept high past the end (4)
    c_ds = cnt_decstep;
    run_session(1'b1, "dec");
    c_rk = cnt_rndkren;
    tick(); tick(); tick();
    check("dec_round10", seen[10], K1_R10);
    check("dec_round9", seen[9], K1_R9);
    check("dec_round0", seen[0], KEY1);
    check("dec_steps_prev_sbox", 128'(cnt_decstep - c_ds), 128'(10));
    check("extra_rk_next_no_write", 128'(cnt_rndkren - c_rk), 128'(0));
    check("extra_rk_next_key_held", dp_rk, KEY1);
`ifdef KEYEXP_CTRL_ERRCHK_EN
    check("err_after_done", 128'(err), 128'(1));
`endif
    rk_next = 1'b0;

    // 4: start before key_ok
    ld_start = 1'b1; tick(); ld_start = 1'b0;
`ifdef KEYEXP_CTRL_ERRCHK_EN
    check("err_cleared_by_ld", 128'(err), 128'(0));
`endif
    c_rk = cnt_rndkren;
    start = 1'b1; mode = 1'b0; tick(); start = 1'b0;
    check("start_in_load_no_write", 128'(cnt_rndkren - c_rk), 128'(0));
    check("start_in_load_no_valid", 128'(rk_valid), 128'(0));
`ifdef KEYEXP_CTRL_ERRCHK_EN
    check("err_start_no_keyok", 128'(err), 128'(1));
`endif

    // 5: ld_start mid-EXP, then reload a new key; ld_start mid-SESS
    load_key(KEY1, 16, 1'b0);
    tick(); tick(); tick(); tick();
    ld_start = 1'b1; tick(); ld_start = 1'b0;
    check("abort_exp_key_ok", 128'(key_ok), 128'(0));
    check("abort_exp_busy", 128'(busy), 128'(1));
    load_key(KEY2, 7, 1'b1);
    check("key2_deckey", dp_dec, K2_R10);
    start = 1'b1; mode = 1'b1; tick(); start = 1'b0;
    check("key2_dec_first", dp_rk, K2_R10);
    rk_next = 1'b1; tick(); tick(); rk_next = 1'b0;
    ld_start = 1'b1; tick(); ld_start = 1'b0;
    check("abort_sess_key_ok", 128'(key_ok), 128'(0));
    check("abort_sess_rk_valid", 128'(rk_valid), 128'(0));

    // 6: asynchronous reset mid-EXP
    load_key(KEY1, 3, 1'b0);
    tick(); tick(); tick();
    c_dk = cnt_dkw;
    @(posedge clk); #3 rst = 1'b1; #1;
    check("async_rst_outputs", 128'({loadkey, keysel, rndkren, rconsel, sboxinsel, deckeywen,
                                     key_ok, busy, rk_valid, rk_round, rk_done}), 128'(0));
    tick(); tick(); rst = 1'b0;
    tick(); tick(); tick(); tick(); tick(); tick(); tick(); tick();
    check("rst_no_deckeywen", 128'(cnt_dkw - c_dk), 128'(0));
    c_rk = cnt_rndkren;
    start = 1'b1; mode = 1'b0; #1;
    check("start_after_rst_rndkren", 128'(rndkren), 128'(0));
    tick(); start = 1'b0;
    check("start_after_rst_valid", 128'(rk_valid), 128'(0));
    check("start_after_rst_no_write", 128'(cnt_rndkren - c_rk), 128'(0));
    load_key(KEY1, 12, 1'b1);
    run_session(1'b0, "final_enc");
    rk_next = 1'b0; tick(); tick();
    check("final_enc_round10", seen[10], K1_R10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
